seg_scan_decoder: RTL and testbench

Receive-side decoder for the multiplexed 8-digit seven-segment scan bus that the clock display drives. It samples `sel`/`seg`, filters scan transitions, decodes each digit's segment pattern and reassembles complete HH-MM-SS frames into binary `hour`/`min`/`sec` with a valid strobe. It is used as a readback/self-check monitor alongside the display driver and as a bench-side scoreboard front end.

---
 rtl/seg_scan_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_seg_scan_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_decoder.sv
// Readback decoder for the multiplexed active-low 8-digit seven-segment scan bus.
// Rebuilds HH-MM-SS frames; define SEG_SCAN_TIMEOUT_EN to enable the stall detector.
module seg_scan_decoder #(
    parameter int unsigned STABLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [7:0] sel,
    input  logic [7:0] seg,
    output logic [4:0] hour,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       sel_err,
    output logic       timeout
);
    localparam int unsigned CNT_W = $clog2(STABLE_CYC + 1);
    localparam logic [3:0]  DASH  = 4'hA;

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_e;

    state_e           state_q, state_d;
    logic [7:0]       sel_q, sel_prev_q;
    logic [6:0]       seg_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             capture_c;
    logic [7:0]       seen_q, seen_d;
    logic [7:0][3:0]  val_q, val_d;
    logic [7:0]       inv_q, inv_d;
    logic [4:0]       hour_q, hour_d;
    logic [5:0]       min_q, min_d, sec_q, sec_d;
    logic             fv_q, fv_d, fe_q, fe_d, se_q, se_d;
    logic [4:0]       dec_c;
    logic [6:0]       hr_sum_c;
    logic             frame_ok_c;
    logic             unused_dp;

    assign unused_dp = seg[7];

    // {invalid, value}; value DASH marks the separator pattern
    function automatic logic [4:0] decode_seg(input logic [6:0] pat);
        case (pat)
            7'h40:   decode_seg = {1'b0, 4'd0};
            7'h79:   decode_seg = {1'b0, 4'd1};
            7'h24:   decode_seg = {1'b0, 4'd2};
            7'h30:   decode_seg = {1'b0, 4'd3};
            7'h19:   decode_seg = {1'b0, 4'd4};
            7'h12:   decode_seg = {1'b0, 4'd5};
            7'h02:   decode_seg = {1'b0, 4'd6};
            7'h78:   decode_seg = {1'b0, 4'd7};
            7'h00:   decode_seg = {1'b0, 4'd8};
            7'h10:   decode_seg = {1'b0, 4'd9};
            7'h3F:   decode_seg = {1'b0, DASH};
            default: decode_seg = {1'b1, 4'd0};
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sel_q      <= '1;
            sel_prev_q <= '1;
            seg_q      <= '1;
            cnt_q      <= '0;
        end else begin
            sel_q      <= sel;
            sel_prev_q <= sel_q;
            seg_q      <= seg[6:0];
            cnt_q      <= cnt_d;
        end
    end

    // Dwell counter: capture fires once, on the step into saturation
    always_comb begin
        cnt_d     = cnt_q;
        capture_c = 1'b0;
        if (sel_q != sel_prev_q) begin
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(STABLE_CYC)) begin
            cnt_d     = cnt_q + CNT_W'(1);
            capture_c = (cnt_q == CNT_W'(STABLE_CYC - 1));
        end
    end

    always_comb begin
        state_d  = state_q;
        seen_d   = seen_q;
        val_d    = val_q;
        inv_d    = inv_q;
        hour_d   = hour_q;
        min_d    = min_q;
        sec_d    = sec_q;
        fv_d     = 1'b0;
        fe_d     = 1'b0;
        se_d     = 1'b0;
        dec_c    = decode_seg(seg_q);

        if (capture_c && !(&sel_q)) begin
            if ($onehot(~sel_q)) begin
                for (int i = 0; i < 8; i++) begin
                    if (!sel_q[i]) begin
                        inv_d[i]  = dec_c[4];
                        val_d[i]  = dec_c[3:0];
                        seen_d[i] = 1'b1;
                    end
                end
            end else begin
                se_d = 1'b1;
            end
        end

        // Check runs on the slot image including this cycle's capture
        hr_sum_c   = 7'(val_d[7]) * 7'd10 + 7'(val_d[6]);
        frame_ok_c = (inv_d == '0) && (val_d[2] == DASH) && (val_d[5] == DASH)
                  && (val_d[0] < 4'd10) && (val_d[1] <= 4'd5)
                  && (val_d[3] < 4'd10) && (val_d[4] <= 4'd5)
                  && (val_d[6] < 4'd10) && (val_d[7] < 4'd10)
                  && (hr_sum_c <= 7'd23);

        case (state_q)
            IDLE:    if (seen_d != '0) state_d = COLLECT;
            COLLECT: state_d = COLLECT;
            CHECK:   state_d = (seen_d == '0) ? IDLE : COLLECT;
            default: state_d = IDLE;
        endcase

        if (seen_d == 8'hFF) begin
            seen_d  = '0;
            state_d = CHECK;
            if (frame_ok_c) begin
                fv_d   = 1'b1;
                hour_d = 5'(hr_sum_c);
                min_d  = 6'(val_d[4]) * 6'd10 + 6'(val_d[3]);
                sec_d  = 6'(val_d[1]) * 6'd10 + 6'(val_d[0]);
            end else begin
                fe_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            seen_q  <= '0;
            val_q   <= '0;
            inv_q   <= '0;
            hour_q  <= '0;
            min_q   <= '0;
            sec_q   <= '0;
            fv_q    <= 1'b0;
            fe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            seen_q  <= seen_d;
            val_q   <= val_d;
            inv_q   <= inv_d;
            hour_q  <= hour_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            fv_q    <= fv_d;
            fe_q    <= fe_d;
            se_q    <= se_d;
        end
    end

    assign hour        = hour_q;
    assign min         = min_q;
    assign sec         = sec_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign sel_err     = se_q;

`ifdef SEG_SCAN_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q;

    // Cycles since the last completed frame, saturating
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (fv_q || fe_q) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_W'(TIMEOUT_CYC)) begin
            tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            tmo_cnt_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            timeout_q <= (tmo_cnt_d >= TMO_W'(TIMEOUT_CYC));
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Randomized bench for seg_scan_decoder against a per-digit frame reference model.
module tb_seg_scan_decoder;
    localparam int STABLE = 16;
`ifdef SEG_SCAN_TIMEOUT_EN
    localparam int TMO = 200;
`else
    localparam int TMO = 1_000_000;
`endif
    localparam int MAXC = 40000;

    logic       clk = 1'b0;
    logic       rstn;
    logic [7:0] sel, seg;
    logic [4:0] hour;
    logic [5:0] min, sec;
    logic       frame_valid, frame_err, sel_err, timeout;

    seg_scan_decoder #(.STABLE_CYC(STABLE), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rstn(rstn), .sel(sel), .seg(seg),
        .hour(hour), .min(min), .sec(sec),
        .frame_valid(frame_valid), .frame_err(frame_err),
        .sel_err(sel_err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    // Expected events indexed by the cycle in which they become visible
    bit exp_fv [MAXC];
    bit exp_fe [MAXC];
    bit exp_se [MAXC];
    bit upd    [MAXC];
    bit rstv   [MAXC];
    int upd_h  [MAXC];
    int upd_m  [MAXC];
    int upd_s  [MAXC];

    int         cur_h, cur_m, cur_s, tmo_m;
    int         slot [8];
    bit [7:0]   m_seen;
    logic [7:0] prev_sel;
    int         run;
    logic [6:0] pat_tab [11];
    logic [7:0] fseg [8];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    function automatic int pat_val(input logic [6:0] p);
        for (int k = 0; k < 11; k++) if (pat_tab[k] == p) return k;
        return -1;
    endfunction

    task automatic model_capture(input int t);
        int nlow = 0;
        int idx  = 0;
        bit ok   = 1'b1;
        int hh, mm, ss;
        for (int k = 0; k < 8; k++) if (!sel[k]) begin nlow++; idx = k; end
        if (nlow == 0) return;
        if (nlow > 1) begin exp_se[t] = 1'b1; return; end
        slot[idx]   = pat_val(seg[6:0]);
        m_seen[idx] = 1'b1;
        if (m_seen != 8'hFF) return;
        m_seen = '0;
        for (int k = 0; k < 8; k++) begin
            if (slot[k] < 0) ok = 1'b0;
            if (k != 2 && k != 5 && slot[k] > 9) ok = 1'b0;
        end
        if (slot[2] != 10 || slot[5] != 10) ok = 1'b0;
        hh = slot[7] * 10 + slot[6];
        mm = slot[4] * 10 + slot[3];
        ss = slot[1] * 10 + slot[0];
        if (slot[4] > 5 || slot[1] > 5 || hh > 23) ok = 1'b0;
        if (ok) begin
            exp_fv[t] = 1'b1;
            upd[t] = 1'b1; upd_h[t] = hh; upd_m[t] = mm; upd_s[t] = ss;
        end else begin
            exp_fe[t] = 1'b1;
        end
    endtask

    // Called once per driven cycle n; inputs reach the DUT at posedge n+1
    task automatic model_step(input int n);
        if (!rstn) begin
            rstv[n+1] = 1'b1;
            exp_fv[n+1] = 1'b0; exp_fe[n+1] = 1'b0; exp_se[n+1] = 1'b0;
            upd[n+1] = 1'b1; upd_h[n+1] = 0; upd_m[n+1] = 0; upd_s[n+1] = 0;
            m_seen = '0; prev_sel = 8'hFF; run = 0;
            for (int k = 0; k < 8; k++) slot[k] = -1;
        end else begin
            if (sel == prev_sel) run++; else run = 1;
            prev_sel = sel;
            if (run == STABLE + 1) model_capture(n + 2);
        end
    endtask

    task automatic check_cycle(input int c);
        logic exp_to;
        if (upd[c]) begin cur_h = upd_h[c]; cur_m = upd_m[c]; cur_s = upd_s[c]; end
        if (rstv[c] || exp_fv[c-1] || exp_fe[c-1]) tmo_m = 0;
        else if (tmo_m < TMO) tmo_m++;
`ifdef SEG_SCAN_TIMEOUT_EN
        exp_to = (tmo_m >= TMO);
`else
        exp_to = 1'b0;
`endif
        check_eq("frame_valid", frame_valid, exp_fv[c]);
        check_eq("frame_err", frame_err, exp_fe[c]);
        check_eq("sel_err", sel_err, exp_se[c]);
        check_eq("hour", hour, cur_h);
        check_eq("min", min, cur_m);
        check_eq("sec", sec, cur_s);
        check_eq("timeout", timeout, exp_to);
    endtask

    task automatic tick(input logic r, input logic [7:0] s, input logic [7:0] g);
        @(posedge clk);
        cyc++;
        if (cyc >= MAXC - 3) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC - 3);
            $fatal(1);
        end
        #1;
        rstn = r; sel = s; seg = g;
        model_step(cyc);
        @(negedge clk);
        check_cycle(cyc);
    endtask

    task automatic show(input logic [7:0] s, input logic [7:0] g, input int n);
        for (int k = 0; k < n; k++) tick(1'b1, s, g);
    endtask

    task automatic do_reset(input int n);
        for (int k = 0; k < n; k++) tick(1'b0, 8'hFF, 8'hFF);
    endtask

    task automatic build_frame(input int h, input int m, input int s);
        fseg[0] = {1'($urandom), pat_tab[s % 10]};
        fseg[1] = {1'($urandom), pat_tab[s / 10]};
        fseg[2] = {1'($urandom), pat_tab[10]};
        fseg[3] = {1'($urandom), pat_tab[m % 10]};
        fseg[4] = {1'($urandom), pat_tab[m / 10]};
        fseg[5] = {1'($urandom), pat_tab[10]};
        fseg[6] = {1'($urandom), pat_tab[h % 10]};
        fseg[7] = {1'($urandom), pat_tab[h / 10]};
    endtask

    task automatic scan_frame(input int dwell, input bit rev);
        int i;
        for (int k = 0; k < 8; k++) begin
            i = rev ? 7 - k : k;
            show(8'(~(8'd1 << i)), fseg[i], dwell);
        end
    endtask

    initial begin
        int a, b, i;
        pat_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10, 7'h3F};
        for (int k = 0; k < 8; k++) slot[k] = -1;
        cur_h = 0; cur_m = 0; cur_s = 0; tmo_m = 0;
        m_seen = '0; prev_sel = 8'hFF; run = 0;
        rstn = 1'b0; sel = 8'hFF; seg = 8'hFF;
        model_step(0);
        do_reset(3);

        build_frame(12, 34, 56); scan_frame(32, 1'b0);
        build_frame(12, 45, 56); scan_frame(32, 1'b0);
        build_frame(25, 34, 56); scan_frame(32, 1'b1);

        // Dwell too short to ever capture
        for (int r = 0; r < 4; r++)
            for (int k = 0; k < 8; k++) show(8'(~(8'd1 << k)), {1'b1, pat_tab[k]}, 8);
        show(8'hFF, 8'hFF, 40);

        show(8'hFC, {1'b1, pat_tab[1]}, 32);
        show(8'hFE, {1'b1, pat_tab[3]}, 16);
        show(8'hFD, {1'b1, pat_tab[4]}, 17);

        build_frame(1, 2, 3); fseg[0] = 8'hFF; scan_frame(32, 1'b0);

        build_frame(8, 9, 10);
        for (int k = 0; k < 5; k++) show(8'(~(8'd1 << k)), fseg[k], 32);
        do_reset(2);
        build_frame(23, 59, 59); scan_frame(32, 1'b1);
        build_frame(0, 0, 0); scan_frame(17, 1'b0);

        for (int f = 0; f < 30; f++) begin
            build_frame($urandom_range(23, 0), $urandom_range(59, 0), $urandom_range(59, 0));
            case ($urandom_range(5, 0))
                0: fseg[$urandom_range(7, 0)] = 8'($urandom);
                1: fseg[2] = {1'b1, pat_tab[3]};
                2: fseg[4] = {1'b0, pat_tab[$urandom_range(9, 6)]};
                default: ;
            endcase
            for (int k = 0; k < 8; k++) begin
                i = (f % 2 == 1) ? 7 - k : k;
                show(8'(~(8'd1 << i)), fseg[i], $urandom_range(40, 15));
                if ($urandom_range(7, 0) == 0) show(8'hFF, 8'($urandom), $urandom_range(20, 1));
                if ($urandom_range(11, 0) == 0) begin
                    a = $urandom_range(7, 0);
                    b = (a + 1 + $urandom_range(6, 0)) % 8;
                    show(8'(~((8'd1 << a) | (8'd1 << b))), 8'($urandom), $urandom_range(30, 10));
                end
            end
        end
        show(8'hFF, 8'hFF, 10);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
